ksa_shuffle_fsm: RTL and testbench



---
 rtl/ksa_shuffle_fsm.sv | 168 ++++++++++++++++
 tb/tb_ksa_shuffle_fsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_shuffle_fsm.sv
// ksa_shuffle_fsm: RC4 key-scheduling shuffle over the 256-byte S-array.
// Walks i = 0..255, accumulates j = j + S[i] + key[i mod KEY_LENGTH] and
// swaps S[i] / S[j] through a memory port whose read data is valid on the
// second cycle an address is held. All outputs are registered.
// Build option: define KSA_SKIP_SELF_SWAP_EN to skip both write states when
// i == j (such an iteration takes 7 cycles instead of 9).
module ksa_shuffle_fsm #(
  parameter int KEY_LENGTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [8*KEY_LENGTH-1:0]   secret_key,
  output logic                      finish,
  output logic [7:0]                address,
  output logic [7:0]                write_data,
  output logic                      write_enable,
  input  logic [7:0]                read_data
);

  localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam logic [KW-1:0] KEY_LAST = KW'(KEY_LENGTH - 1);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_READ_SI    = 4'd1,
    ST_WAIT_SI    = 4'd2,
    ST_CALC_J     = 4'd3,
    ST_READ_SJ    = 4'd4,
    ST_WAIT_SJ    = 4'd5,
    ST_CAPTURE_SJ = 4'd6,
    ST_WRITE_SI   = 4'd7,
    ST_WRITE_SJ   = 4'd8,
    ST_INCR       = 4'd9,
    ST_DONE       = 4'd10
  } state_t;

  state_t                    state_q;
  logic [7:0]                i_q;
  logic [7:0]                j_q;
  logic [KW-1:0]             key_idx_q;
  logic [8*KEY_LENGTH-1:0]   key_q;
  logic [7:0]                s_i_q;
  logic                      finish_q;
  logic [7:0]                address_q;
  logic [7:0]                write_data_q;
  logic                      write_enable_q;

  logic [7:0]                key_byte_s;
  logic [7:0]                j_sum_s;

  assign finish       = finish_q;
  assign address      = address_q;
  assign write_data   = write_data_q;
  assign write_enable = write_enable_q;

  // Select the current key byte; byte 0 sits in the most significant bits.
  always_comb begin
    key_byte_s = 8'h00;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      key_byte_s = (key_idx_q == KW'(k)) ? key_q[8*(KEY_LENGTH-1-k) +: 8] : key_byte_s;
    end
  end

  // New j from S[i] on the read bus; 8-bit sum, carries dropped.
  assign j_sum_s = j_q + read_data + key_byte_s;

  // Shuffle sequencer with registered memory-port and finish outputs.
  // write_data_q doubles as the S[j] holding register: it is loaded from the
  // read bus in CAPTURE_SJ and driven straight out during WRITE_SI.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      i_q            <= 8'h00;
      j_q            <= 8'h00;
      key_idx_q      <= '0;
      key_q          <= '0;
      s_i_q          <= 8'h00;
      finish_q       <= 1'b0;
      address_q      <= 8'h00;
      write_data_q   <= 8'h00;
      write_enable_q <= 1'b0;
    end else begin
      finish_q       <= 1'b0;
      write_enable_q <= 1'b0;
      write_data_q   <= 8'h00;
      case (state_q)
        ST_IDLE: begin
          address_q <= 8'h00;
          if (start) begin
            i_q       <= 8'h00;
            j_q       <= 8'h00;
            key_idx_q <= '0;
            key_q     <= secret_key;
            state_q   <= ST_READ_SI;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_READ_SI: begin
          state_q <= ST_WAIT_SI;
        end
        ST_WAIT_SI: begin
          state_q <= ST_CALC_J;
        end
        ST_CALC_J: begin
          s_i_q     <= read_data;
          j_q       <= j_sum_s;
          address_q <= j_sum_s;
          state_q   <= ST_READ_SJ;
        end
        ST_READ_SJ: begin
          state_q <= ST_WAIT_SJ;
        end
        ST_WAIT_SJ: begin
          state_q <= ST_CAPTURE_SJ;
        end
        ST_CAPTURE_SJ: begin
`ifdef KSA_SKIP_SELF_SWAP_EN
          if (i_q == j_q) begin
            state_q <= ST_INCR;
          end else begin
            address_q      <= i_q;
            write_data_q   <= read_data;
            write_enable_q <= 1'b1;
            state_q        <= ST_WRITE_SI;
          end
`else
          address_q      <= i_q;
          write_data_q   <= read_data;
          write_enable_q <= 1'b1;
          state_q        <= ST_WRITE_SI;
`endif
        end
        ST_WRITE_SI: begin
          address_q      <= j_q;
          write_data_q   <= s_i_q;
          write_enable_q <= 1'b1;
          state_q        <= ST_WRITE_SJ;
        end
        ST_WRITE_SJ: begin
          state_q <= ST_INCR;
        end
        ST_INCR: begin
          key_idx_q <= (key_idx_q == KEY_LAST) ? '0 : key_idx_q + KW'(1);
          if (i_q == 8'hFF) begin
            address_q <= 8'h00;
            finish_q  <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            i_q       <= i_q + 8'd1;
            address_q <= i_q + 8'd1;
            state_q   <= ST_READ_SI;
          end
        end
        ST_DONE: begin
          address_q <= 8'h00;
          state_q   <= ST_IDLE;
        end
        default: begin
          address_q <= 8'h00;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Testbench for ksa_shuffle_fsm: 2-cycle-read memory model, software RC4 KSA
// reference, write-by-write checking, latency and reset corner cases.
module tb_ksa_shuffle_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic        finish;
  logic [7:0]  address;
  logic [7:0]  write_data;
  logic        write_enable;
  logic [7:0]  read_data;

  always #5 clk = ~clk;

  ksa_shuffle_fsm #(.KEY_LENGTH(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .secret_key   (secret_key),
    .finish       (finish),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data    (read_data)
  );

`ifdef KSA_SKIP_SELF_SWAP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // Working memory: registered read (data valid on 2nd cycle of an address).
  logic [7:0] mem [256];
  logic [7:0] rd_q;
  logic       mem_init = 1'b0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (write_enable) begin
      mem[address] <= write_data;
    end
    rd_q <= mem[address];
  end
  assign read_data = rd_q;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { int iter; logic [7:0] addr; logic [7:0] val; } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[5];
  int   fin_s[256];
  int   end_cyc[256];
  bit   self_at[256];
  int   exp_lat;
  int   exp_wr;
  int   n_self;
  bit   mon_en = 1'b0;
  int   wr_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain software RC4 KSA, producing expected writes and timing.
  task automatic model(input logic [23:0] key);
    int s[256];
    int j;
    int cyc;
    int kb;
    int t;
    wr_t w;
    exp_q.delete();
    j = 0; cyc = 0; n_self = 0;
    for (int k = 0; k < 256; k++) s[k] = k;
    for (int i = 0; i < 256; i++) begin
      kb = int'((key >> (8 * (2 - (i % 3)))) & 24'hFF);
      j = (j + s[i] + kb) % 256;
      self_at[i] = (i == j);
      if (i == j) n_self++;
      if (SKIP && i == j) begin
        cyc += 7;
      end else begin
        w.a = 8'(i); w.d = 8'(s[j]); exp_q.push_back(w);
        w.a = 8'(j); w.d = 8'(s[i]); exp_q.push_back(w);
        cyc += 9;
      end
      t = s[i]; s[i] = s[j]; s[j] = t;
      end_cyc[i] = cyc;
    end
    fin_s   = s;
    exp_lat = cyc + 1;
    exp_wr  = exp_q.size();
  endtask

  // Every write strobe is compared against the next expected write.
  always @(negedge clk) begin
    if (mon_en && write_enable) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("wr_extra", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", address, e.a);
        check("wr_data", write_data, e.d);
      end
    end else if (mon_en) begin
      check("wdata_idle", write_data, 32'd0);
    end
  end

  // Full shuffle: start is accepted on the next posedge (memory re-initialised
  // on the same edge). Called back-to-back, start is high in the IDLE cycle
  // that follows DONE.
  task automatic run(input logic [23:0] key, input int repulse, input bit use_tbl);
    int cyc;
    int bad;
    bit got;
    model(key);
    secret_key = key; mem_init = 1'b1; start = 1'b1; wr_count = 0; mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0; start = 1'b0;
    secret_key = key ^ 24'h5A5A5A;
    cyc = 1; got = 1'b0;
    while (cyc <= exp_lat + 20) begin
      if (use_tbl) begin
        foreach (tbl[e]) begin
          if (cyc == end_cyc[tbl[e].iter]) check("tbl_mem", mem[tbl[e].addr], tbl[e].val);
        end
      end
      if (finish) begin
        got = 1'b1;
        break;
      end
      start = (cyc == repulse);
      if (cyc == repulse) secret_key = 24'h123456;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check("finish_seen", got, 32'd1);
    check("finish_latency", cyc, exp_lat);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== 8'(fin_s[k])) bad++;
    check("final_mem_mismatches", bad, 32'd0);
    check("write_count", wr_count, exp_wr);
    @(negedge clk);
    check("finish_width", finish, 32'd0);
    check("idle_we", write_enable, 32'd0);
    check("idle_addr", address, 32'd0);
    mon_en = 1'b0;
  endtask

  // Reset asserted during WRITE_SI of iteration i=10.
  task automatic reset_mid(input logic [23:0] key);
    int cyc;
    int target;
    int pulses;
    model(key);
    target = end_cyc[9] + 7;
    secret_key = key; mem_init = 1'b1; start = 1'b1; mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0; start = 1'b0; cyc = 1;
    while (cyc < target) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!(SKIP && self_at[10])) begin
      check("pre_reset_we", write_enable, 32'd1);
      check("pre_reset_addr", address, 32'd10);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_we", write_enable, 32'd0);
    check("rst_finish", finish, 32'd0);
    check("rst_addr", address, 32'd0);
    check("rst_wdata", write_data, 32'd0);
    mon_en = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (finish) pulses++;
    end
    check("no_finish_after_reset", pulses, 32'd0);
    check("still_idle_addr", address, 32'd0);
  endtask

  initial begin
    tbl[0] = '{0, 8'h00, 8'h00};
    tbl[1] = '{1, 8'h01, 8'h03};
    tbl[2] = '{1, 8'h03, 8'h01};
    tbl[3] = '{2, 8'h02, 8'h4E};
    tbl[4] = '{2, 8'h4E, 8'h02};

    reset = 1'b1; start = 1'b0; secret_key = 24'h000000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_finish", finish, 32'd0);
    check("reset_we", write_enable, 32'd0);
    check("reset_addr", address, 32'd0);
    check("reset_wdata", write_data, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_no_start_we", write_enable, 32'd0);
    check("idle_no_start_finish", finish, 32'd0);

    run(24'h000249, -1, 1'b1);
    run(24'h000249, 500, 1'b0);
    run(24'hFFFFFF, -1, 1'b0);
    reset_mid(24'h000249);
    run(24'h000249, -1, 1'b0);
    repeat (2) run(24'($urandom), -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
